// File: rtl/fpu_scheduler.sv
// Round-robin scheduler that shares one single-precision FPU between two requesters,
// with a watchdog that aborts operations whose done never arrives.
module fpu_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [1:0]  req_op,
    output logic [31:0] fpu_op_a,
    output logic [31:0] fpu_op_b,
    output logic        fpu_op,
    output logic        fpu_start,
    input  logic [31:0] fpu_result,
    input  logic [3:0]  fpu_flags,
    input  logic        fpu_done,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_result,
    output logic [3:0]  resp_flags,
    output logic        resp_timeout,
    output logic        busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic             owner;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             grant_idx;

    // One-hot grant from the valid requests; the requester not served last wins a tie.
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign grant_idx = req_ready[1];

    // Sequencer: capture, launch, watch for done or timeout, respond.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            cnt          <= '0;
            fpu_op_a     <= '0;
            fpu_op_b     <= '0;
            fpu_op       <= 1'b0;
            fpu_start    <= 1'b0;
            resp_valid   <= 2'b00;
            resp_result  <= '0;
            resp_flags   <= '0;
            resp_timeout <= 1'b0;
            busy         <= 1'b0;
        end else begin
            fpu_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_ready != 2'b00) begin
                        owner     <= grant_idx;
                        fpu_op_a  <= grant_idx ? req_a[63:32] : req_a[31:0];
                        fpu_op_b  <= grant_idx ? req_b[63:32] : req_b[31:0];
                        fpu_op    <= grant_idx ? req_op[1] : req_op[0];
                        fpu_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (fpu_done) begin
                        resp_result  <= fpu_result;
                        resp_flags   <= fpu_flags;
                        resp_timeout <= 1'b0;
                        resp_valid   <= {owner, ~owner};
                        state        <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        resp_result  <= '0;
                        resp_flags   <= '0;
                        resp_timeout <= 1'b1;
                        resp_valid   <= {owner, ~owner};
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    resp_valid <= 2'b00;
                    last_grant <= owner;
                    fpu_op_a   <= '0;
                    fpu_op_b   <= '0;
                    fpu_op     <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fpu_scheduler.md
# fpu_scheduler

Sequencing and arbitration front-end for the shared single-precision FPU. Two requesters, for example the command decoder and the test-pattern engine, submit operand pairs through valid/ready handshakes. The scheduler grants the FPU to one requester at a time in round-robin order, launches the operation with a one-cycle start pulse, waits for the FPU's done, and returns the result and flags to the owning requester. A watchdog prevents a hung FPU from locking up both requesters.

## Interface
- TIMEOUT_CYCLES, default 64: maximum cycles spent in WAIT before the operation is aborted; legal range 2..1024.
- clock100KHz  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- req_valid  in  2  request present, requester i on bit i.
- req_ready  out  2  request accepted this cycle, requester i on bit i.
- req_a  in  64  operand A, requester i on [32i+31:32i].
- req_b  in  64  operand B, same packing as req_a.
- req_op  in  2  operation select, 0 = add, 1 = subtract, requester i on bit i.
- fpu_op_a  out  32  operand A to the FPU.
- fpu_op_b  out  32  operand B to the FPU.
- fpu_op  out  1  operation to the FPU.
- fpu_start  out  1  one-cycle launch pulse to the FPU.
- fpu_result  in  32  FPU result; valid only when fpu_done=1.
- fpu_flags  in  4  FPU flags {overflow, underflow, inexact, invalid}; valid only when fpu_done=1.
- fpu_done  in  1  FPU completion; single-cycle pulse.
- resp_valid  out  2  one-hot response strobe to the owning requester.
- resp_result  out  32  result returned to the requester.
- resp_flags  out  4  flags returned to the requester.
- resp_timeout  out  1  asserted with resp_valid when the operation was aborted by the watchdog.
- busy  out  1  high in any state other than IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE, no request:** when req_valid = 00, remain in IDLE.
- **IDLE, arbitration:** req_ready is one-hot and combinational from req_valid, and is nonzero only in IDLE.
  - If a single requester is valid, it is granted.
  - If both are valid, the requester other than last_grant is granted.
- **IDLE, acceptance:** on the accepting edge, capture the owner index and that requester's a, b and op into internal registers, then go to ISSUE.
- **ISSUE:** fpu_start=1 for exactly this cycle, then go to WAIT.
  - fpu_op_a, fpu_op_b and fpu_op are driven from the captured registers.
  - These outputs hold stable from ISSUE until the end of RESP, and are 0 in IDLE.
- **WAIT, watchdog:** cnt is cleared on entry and increments every cycle.
- **WAIT, normal completion:** if fpu_done=1, latch fpu_result and fpu_flags into the response registers, set timeout=0, and go to RESP.
- **WAIT, timeout:** if fpu_done=0 and cnt == TIMEOUT_CYCLES-1, set result=0, flags=0, timeout=1, and go to RESP.
- **Done versus timeout:** if fpu_done arrives on the final watchdog cycle, done wins.
- **RESP:** for one cycle, assert resp_valid[owner]=1, with resp_result, resp_flags and resp_timeout valid.
  - There is no response backpressure; requesters must sample in this cycle.
  - Update last_grant=owner, then return to IDLE.
- **Ignored done:** fpu_done outside WAIT is ignored, including in the ISSUE cycle.
- **Response outputs:** resp_result, resp_flags and resp_timeout hold their last value outside RESP; only resp_valid qualifies them.
- **Counter width:** cnt is $clog2(TIMEOUT_CYCLES) bits wide and never wraps, because exit happens at TIMEOUT_CYCLES-1.

## Timing
- **Reset values:** req_ready=00, fpu_op_a=0, fpu_op_b=0, fpu_op=0, fpu_start=0, resp_valid=00, resp_result=0, resp_flags=0, resp_timeout=0, busy=0. Internally last_grant=1, so requester 0 wins the first contention.
- **Reset mid-operation:** any in-flight operation is dropped silently, with no response. A later fpu_done from the FPU is ignored, since the scheduler is in IDLE.
- **Acceptance:** occurs on edge T, when req_valid and req_ready are both high. fpu_start is high in cycle T+1.
- **Latency:** if fpu_done is high in the k-th cycle after the start cycle (k≥1), resp_valid is high k+1 cycles after the start cycle.
  - End-to-end latency from acceptance is k+2 cycles.
  - The earliest next acceptance is the cycle after RESP, giving a minimum of k+3 cycles per operation.
- **Timeout latency:** resp_valid occurs TIMEOUT_CYCLES+1 cycles after fpu_start.
- **Requester obligations:**
  - A requester must hold req_valid and its operands until accepted.
  - Deasserting req_valid before acceptance is allowed; nothing is captured.
- **Simultaneous events:** a new request arriving during RESP is not accepted until IDLE. The round-robin decision uses the last_grant updated in RESP.

## Test plan
- **Single operation:** reset, req_valid=01, a=0x3F800000, b=0x40000000, op=0, FPU model with done at k=3 returning 0x40400000 and flags 0 -> req_ready=01 for one cycle, fpu_start one cycle later, resp_valid=01 with result 0x40400000 and resp_timeout=0, exactly 5 cycles after acceptance.
- **Contention and fairness:** req_valid=11 held constant for 4 operations -> grant order 0,1,0,1. Each response is one-hot to the granted requester, and no two grants occur without an intervening RESP.
- **Watchdog:** TIMEOUT_CYCLES=8 with the FPU never asserting done -> resp_valid after 9 cycles following fpu_start, with resp_timeout=1 and result 0. The next request is accepted normally.
- **Done on the last cycle:** fpu_done asserted exactly when cnt=TIMEOUT_CYCLES-1 -> resp_timeout=0 and the FPU result is returned.
- **Spurious and stray done:**
  - fpu_done pulsed in IDLE and in ISSUE -> no state change and no resp_valid.
  - reset low during WAIT, then fpu_done after reset is released -> all outputs at reset values and busy=0.
- **Operand stability:** requester 0 changes req_a after acceptance -> fpu_op_a keeps the captured value through RESP.
